// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for a small LEGv8-style datapath.
// Fetches into IR, decodes to a 29-bit control word plus 64-bit literal, and counts retired instructions.
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic [4:0]       status,
  output logic [28:0]      control_word,
  output logic [63:0]      literal,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, ILLEGAL} state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [4:0]  FS_ADD  = 5'b01000;

  state_t      state, next_state;
  logic [31:0] ir;
  logic [4:0]  rd, rn, rm;
  logic [63:0] mem_offset;

  logic [4:0]  sa, sb, da, fs;
  logic        reg_write, mem_write, bsel, en_mem, en_alu, sl, il;
  logic [1:0]  ps;

  logic        unused_status;

  assign rd = ir[4:0];
  assign rn = ir[9:5];
  assign rm = ir[20:16];
  assign mem_offset = {{55{ir[20]}}, ir[20:12]};
  assign unused_status = ^status[4:1];

  assign control_word = {sa, sb, da, reg_write, mem_write, fs, bsel, en_mem, en_alu, sl, il, ps};
  assign illegal      = (state == ILLEGAL);

  always_comb begin
    sa         = '0;
    sb         = '0;
    da         = '0;
    fs         = '0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    bsel       = 1'b0;
    en_mem     = 1'b0;
    en_alu     = 1'b0;
    sl         = 1'b0;
    il         = 1'b0;
    ps         = 2'b00;
    literal    = '0;
    next_state = state;

    unique case (state)
      FETCH: begin
        il         = 1'b1;
        next_state = EXEC;
      end

      EXEC: begin
        next_state = FETCH;
        if (ir[31:21] == OP_ADD || ir[31:21] == OP_SUB ||
            ir[31:21] == OP_AND || ir[31:21] == OP_ORR) begin
          sa        = rn;
          sb        = rm;
          da        = rd;
          reg_write = 1'b1;
          en_alu    = 1'b1;
          ps        = 2'b01;
          unique case (ir[31:21])
            OP_ADD:  fs = FS_ADD;
            OP_SUB:  begin fs = 5'b01001; sl = 1'b1; end
            OP_AND:  fs = 5'b00000;
            default: fs = 5'b00100;
          endcase
        end else if (ir[31:22] == OP_ADDI) begin
          sa        = rn;
          da        = rd;
          bsel      = 1'b1;
          fs        = FS_ADD;
          reg_write = 1'b1;
          en_alu    = 1'b1;
          ps        = 2'b01;
          literal   = {52'b0, ir[21:10]};
        end else if (ir[31:21] == OP_LDUR) begin
          // Address phase only; the register write happens in MEM.
          sa         = rn;
          bsel       = 1'b1;
          fs         = FS_ADD;
          literal    = mem_offset;
          next_state = MEM;
        end else if (ir[31:21] == OP_STUR) begin
          sa        = rn;
          sb        = rd;
          bsel      = 1'b1;
          fs        = FS_ADD;
          mem_write = 1'b1;
          ps        = 2'b01;
          literal   = mem_offset;
        end else if (ir[31:24] == OP_CBZ) begin
          sa      = 5'd31;
          sb      = rd;
          fs      = FS_ADD;
          ps      = status[0] ? 2'b10 : 2'b01;
          literal = {{45{ir[23]}}, ir[23:5]};
        end else if (ir[31:26] == OP_B) begin
          ps      = 2'b10;
          literal = {{38{ir[25]}}, ir[25:0]};
        end else begin
          next_state = ILLEGAL;
        end
      end

      MEM: begin
        sa         = rn;
        da         = rd;
        bsel       = 1'b1;
        fs         = FS_ADD;
        reg_write  = 1'b1;
        en_mem     = 1'b1;
        ps         = 2'b01;
        literal    = mem_offset;
        next_state = FETCH;
      end

      default: next_state = ILLEGAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      ir      <= '0;
      retired <= '0;
    end else begin
      state <= next_state;
      if (state == FETCH) ir <= instruction;
      // Any exit to FETCH with a moving PC completes an instruction.
      if (next_state == FETCH && ps != 2'b00) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed and random instructions checked against a decode model.
// A narrow counter width lets the retired count wrap within a short run.
module tb_control_sequencer;

  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [31:0]      instruction;
  logic [4:0]       status;
  logic [28:0]      control_word;
  logic [63:0]      literal;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned exp_retired = 0;
  logic [28:0] exec_cw;
  logic [63:0] exec_lit;
  logic [28:0] mem_cw;

  localparam logic [28:0] CW_FETCH = 29'h4;

  always #5 clock = ~clock;

  control_sequencer #(.CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .status       (status),
    .control_word (control_word),
    .literal      (literal),
    .illegal      (illegal),
    .retired      (retired)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [28:0] pack(int sa, int sb, int da, int rw, int mw, int fs,
                                        int bsel, int enm, int ena, int sl, int il, int ps);
    return 29'((sa << 24) | (sb << 19) | (da << 14) | (rw << 13) | (mw << 12) | (fs << 7) |
               (bsel << 6) | (enm << 5) | (ena << 4) | (sl << 3) | (il << 2) | ps);
  endfunction

  function automatic logic [63:0] sext(longint v, int bits);
    longint half = longint'(1) << (bits - 1);
    return 64'((v >= half) ? v - (half * 2) : v);
  endfunction

  // kind: 0 = completes to FETCH, 1 = goes on to MEM, 2 = undefined opcode
  task automatic model_exec(input logic [31:0] i, input logic z,
                            output logic [28:0] cw, output logic [63:0] lit, output int kind);
    longint u = longint'(i);
    int rd = int'(u & 31);
    int rn = int'((u >> 5) & 31);
    int rm = int'((u >> 16) & 31);
    int op11 = int'(u >> 21);
    cw = '0; lit = '0; kind = 0;
    if      (op11 == 'h458) cw = pack(rn, rm, rd, 1, 0, 8, 0, 0, 1, 0, 0, 1);
    else if (op11 == 'h658) cw = pack(rn, rm, rd, 1, 0, 9, 0, 0, 1, 1, 0, 1);
    else if (op11 == 'h450) cw = pack(rn, rm, rd, 1, 0, 0, 0, 0, 1, 0, 0, 1);
    else if (op11 == 'h550) cw = pack(rn, rm, rd, 1, 0, 4, 0, 0, 1, 0, 0, 1);
    else if (op11 == 'h7C2) begin
      cw = pack(rn, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0, 0);
      lit = sext((u >> 12) & 'h1FF, 9);
      kind = 1;
    end else if (op11 == 'h7C0) begin
      cw = pack(rn, rd, 0, 0, 1, 8, 1, 0, 0, 0, 0, 1);
      lit = sext((u >> 12) & 'h1FF, 9);
    end else if ((u >> 22) == 'h244) begin
      cw = pack(rn, 0, rd, 1, 0, 8, 1, 0, 1, 0, 0, 1);
      lit = 64'((u >> 10) & 'hFFF);
    end else if ((u >> 24) == 'hB4) begin
      cw = pack(31, rd, 0, 0, 0, 8, 0, 0, 0, 0, 0, z ? 2 : 1);
      lit = sext((u >> 5) & 'h7FFFF, 19);
    end else if ((u >> 26) == 5) begin
      cw = pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
      lit = sext(u & 'h3FFFFFF, 26);
    end else kind = 2;
  endtask

  task automatic check_invariants(input string tag);
    check({tag, "_mem_alu_excl"}, 64'(control_word[5] & control_word[4]), 64'd0);
    check({tag, "_rw_mw_excl"},   64'(control_word[13] & control_word[12]), 64'd0);
  endtask

  // Entered while in FETCH, away from the clock edge; returns in FETCH (or ILLEGAL).
  task automatic run_instr(input logic [31:0] i, input logic z, input string tag);
    logic [28:0] ecw;
    logic [63:0] elit;
    int kind;
    model_exec(i, z, ecw, elit, kind);
    instruction = i;
    status = {4'($urandom), z};
    check({tag, "_fetch_cw"}, 64'(control_word), 64'(CW_FETCH));
    check({tag, "_fetch_lit"}, literal, 64'd0);
    check({tag, "_fetch_retired"}, 64'(retired), 64'(exp_retired));
    @(posedge clock); #1;
    instruction = $urandom;
    exec_cw = control_word;
    exec_lit = literal;
    check({tag, "_exec_cw"}, 64'(control_word), 64'(kind == 2 ? 29'd0 : ecw));
    check({tag, "_exec_lit"}, literal, kind == 2 ? 64'd0 : elit);
    check({tag, "_exec_illegal"}, 64'(illegal), 64'd0);
    check_invariants({tag, "_exec"});
    if (kind == 1) begin
      @(posedge clock); #1;
      mem_cw = control_word;
      check({tag, "_mem_cw"}, 64'(control_word),
            64'(ecw | pack(0, 0, int'(i & 32'd31), 1, 0, 0, 0, 1, 0, 0, 0, 1)));
      check({tag, "_mem_lit"}, literal, elit);
      check_invariants({tag, "_mem"});
    end
    @(posedge clock); #1;
    if (kind == 2) begin
      check({tag, "_illegal_flag"}, 64'(illegal), 64'd1);
      check({tag, "_illegal_cw"}, 64'(control_word), 64'd0);
    end else begin
      exp_retired = (exp_retired + 1) % (1 << CNT_W);
      check({tag, "_back_fetch_cw"}, 64'(control_word), 64'(CW_FETCH));
      check({tag, "_retired"}, 64'(retired), 64'(exp_retired));
    end
  endtask

  function automatic logic [31:0] random_instr();
    logic [31:0] u = $urandom;
    case ($urandom_range(0, 8))
      0: return {11'h458, u[20:0]};
      1: return {11'h658, u[20:0]};
      2: return {11'h450, u[20:0]};
      3: return {11'h550, u[20:0]};
      4: return {11'h7C2, u[20:0]};
      5: return {11'h7C0, u[20:0]};
      6: return {10'h244, u[21:0]};
      7: return {8'hB4, u[23:0]};
      default: return {6'h05, u[25:0]};
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    instruction = '0;
    status = '0;
    #3;
    check("reset_cw", 64'(control_word), 64'(CW_FETCH));
    check("reset_illegal", 64'(illegal), 64'd0);
    check("reset_retired", 64'(retired), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    run_instr(32'h8B030041, 1'b0, "add");
    check("add_sa", 64'(exec_cw[28:24]), 64'd2);
    check("add_sb", 64'(exec_cw[23:19]), 64'd3);
    check("add_da", 64'(exec_cw[18:14]), 64'd1);
    check("add_fs", 64'(exec_cw[11:7]), 64'h08);
    check("add_ps", 64'(exec_cw[1:0]), 64'd1);

    run_instr(32'hF84080C5, 1'b0, "ldur");
    check("ldur_exec_lit8", exec_lit, 64'd8);
    check("ldur_exec_ps", 64'(exec_cw[1:0]), 64'd0);
    check("ldur_mem_da", 64'(mem_cw[18:14]), 64'd5);
    check("ldur_mem_enmem", 64'(mem_cw[5]), 64'd1);

    run_instr(32'hB4000067, 1'b1, "cbz_taken");
    check("cbz_taken_ps", 64'(exec_cw[1:0]), 64'd2);
    check("cbz_taken_lit", exec_lit, 64'd3);
    run_instr(32'hB4000067, 1'b0, "cbz_not_taken");
    check("cbz_not_taken_ps", 64'(exec_cw[1:0]), 64'd1);

    run_instr(32'h17FFFFFF, 1'b0, "b_back");
    check("b_back_lit", exec_lit, 64'hFFFF_FFFF_FFFF_FFFF);

    for (int n = 0; n < 40; n++) run_instr(random_instr(), 1'($urandom), "rand");

    // Reset partway through the MEM phase of a load.
    instruction = 32'hF84080C5;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("midmem_regwrite_before", 64'(control_word[13]), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("midmem_async_cw", 64'(control_word), 64'(CW_FETCH));
    check("midmem_async_retired", 64'(retired), 64'd0);
    check("midmem_async_illegal", 64'(illegal), 64'd0);
    for (int n = 0; n < 3; n++) begin
      @(posedge clock); #1;
      check("midmem_no_regwrite", 64'(control_word[13]), 64'd0);
    end
    exp_retired = 0;
    @(negedge clock);
    reset = 1'b1;
    run_instr(32'h8B030041, 1'b0, "post_reset_add");

    run_instr(32'h00000000, 1'b0, "zero");
    for (int n = 0; n < 12; n++) begin
      @(posedge clock); #1;
      instruction = $urandom;
      check("illegal_hold_flag", 64'(illegal), 64'd1);
      check("illegal_hold_cw", 64'(control_word), 64'd0);
      check("illegal_hold_lit", literal, 64'd0);
      check("illegal_hold_retired", 64'(retired), 64'(exp_retired));
    end
    reset = 1'b0;
    #1;
    check("illegal_reset_flag", 64'(illegal), 64'd0);
    check("illegal_reset_cw", 64'(control_word), 64'(CW_FETCH));
    exp_retired = 0;
    @(negedge clock);
    reset = 1'b1;
    run_instr(32'hF84080C5, 1'b0, "recover_ldur");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
